// File: rtl/conv_relu_pool.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster-ordered conv feature map.
// A half-width line buffer holds the even-row horizontal maxima until the odd row arrives.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | accepting beats, tracking frame position and finish handshake
// ERR   | protocol violation seen; inputs ignored until reset
module conv_relu_pool #(
    parameter int DATA_W = 32,
    parameter int MAP_W  = 12,
    parameter int MAP_H  = 12
) (
    input  logic              h_clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_finish,
    input  logic              in_invalid,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);

    localparam int CW  = (MAP_W > 2) ? $clog2(MAP_W) : 1;
    localparam int RW  = (MAP_H > 2) ? $clog2(MAP_H) : 1;
    localparam int LBD = MAP_W / 2;
    localparam int IW  = (LBD > 1) ? $clog2(LBD) : 1;

    typedef enum logic {S_RUN, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic [DATA_W-1:0] linebuf_q [LBD];
    logic              lb_we;
    logic [IW-1:0]     lb_idx;
    logic [DATA_W-1:0] lb_rd;

    logic [DATA_W-1:0] relu;
    logic [DATA_W-1:0] pm;
    logic              last_pos;
    logic              err_now;

    assign relu     = in_data[DATA_W-1] ? '0 : in_data;
    assign pm       = (hold_q > relu) ? hold_q : relu;
    assign lb_idx   = IW'(col_q >> 1);
    assign lb_rd    = linebuf_q[lb_idx];
    assign last_pos = (col_q == CW'(MAP_W - 1)) && (row_q == RW'(MAP_H - 1));

    // A finish that lands together with the frame's last beat is legal; one
    // arriving with a new frame's first beat releases the outstanding frame.
    assign err_now = in_invalid
                   | (in_finish & ~done_q & ~(in_valid & last_pos))
                   | (in_valid & done_q & ~in_finish);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        done_d      = done_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        lb_we       = 1'b0;
        if (state_q == S_RUN) begin
            if (err_now) begin
                state_d = S_ERR;
            end else begin
                if (in_valid) begin
                    if (!col_q[0]) begin
                        hold_d = relu;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = (lb_rd > pm) ? lb_rd : pm;
                        out_last_d  = last_pos;
                    end
                    if (col_q == CW'(MAP_W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == RW'(MAP_H - 1)) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                if (in_valid && last_pos && !in_finish) begin
                    done_d = 1'b1;
                end else if (in_finish || in_valid) begin
                    done_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge h_clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer is deliberately unreset: every entry is rewritten on an even row before use.
    always_ff @(posedge h_clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pm;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed bench for conv_relu_pool on a 4x4 map with hand-computed pooled results.
module tb_conv_relu_pool;

    logic        h_clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_finish;
    logic        in_invalid;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    int          fv [16];
    logic [31:0] got_d [$];
    logic        got_l [$];

    conv_relu_pool #(.DATA_W(32), .MAP_W(4), .MAP_H(4)) dut (
        .h_clk     (h_clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_finish (in_finish),
        .in_invalid(in_invalid),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    always @(negedge h_clk) begin
        if (out_valid === 1'b1) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_finish = 1'b0; in_invalid = 1'b0;
        repeat (2) @(posedge h_clk);
        #1 reset = 1'b0;
    endtask

    // Drives fv[0..n-1]; gap_mode inserts i%4 idle cycles after beat i.
    task automatic send_beats(input int n, input bit gap_mode, input bit fin_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = fv[i];
            in_finish = fin_last && (i == n - 1);
            @(posedge h_clk);
            #1 in_valid = 1'b0; in_finish = 1'b0;
            if (gap_mode) begin
                repeat (i % 4) @(posedge h_clk);
                #1;
            end
        end
        repeat (2) @(posedge h_clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge h_clk);
        n_checks++;
        if ({out_valid, out_data, out_last, err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h l=%b e=%b, expected all zero",
                     out_valid, out_data, out_last, err);
        end
        #1;
    endtask

    task automatic test_ramp();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = i + 1;
        send_beats(16, 1'b0, 1'b1);
        n_checks++;
        if (got_d.size() != 4) begin
            n_fail++; $display("FAIL ramp_count: got %0d beats, expected 4", got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL ramp_beat%0d: got d=%h l=%b, expected d=%h l=%b", i,
                         (i < got_d.size()) ? got_d[i] : 32'hx, (i < got_l.size()) ? got_l[i] : 1'bx,
                         exp[i], (i == 3));
            end
        end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL ramp_err: got %b, expected 0", err); end
    endtask

    task automatic test_negated();
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = -(i + 1);
        send_beats(16, 1'b0, 1'b1);
        n_checks++;
        if (got_d.size() != 4) begin
            n_fail++; $display("FAIL relu_count: got %0d beats, expected 4", got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL relu_beat%0d: got %h, expected 0", i, (i < got_d.size()) ? got_d[i] : 32'hx);
            end
        end
    endtask

    task automatic test_mixed();
        logic [31:0] exp [4] = '{32'd7, 32'h7FFF_FFFF, 32'd0, 32'd30};
        got_d.delete(); got_l.delete();
        fv = '{-5, 3, 32'h7FFF_FFFF, 0, 7, -1, 0, 0, -100, -2, 10, 20, -3, -4, 30, 25};
        send_beats(16, 1'b0, 1'b1);
        n_checks++;
        if (got_d.size() != 4) begin
            n_fail++; $display("FAIL mixed_count: got %0d beats, expected 4", got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL mixed_beat%0d: got %h, expected %h", i,
                         (i < got_d.size()) ? got_d[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [8] = '{32'd6, 32'd8, 32'd14, 32'd16, 32'd16, 32'd14, 32'd8, 32'd6};
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = i + 1;
        send_beats(16, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) fv[i] = 16 - i;
        send_beats(16, 1'b1, 1'b0);
        repeat (5) @(posedge h_clk);
        #1 in_finish = 1'b1;
        @(posedge h_clk);
        #1 in_finish = 1'b0;
        @(posedge h_clk);
        #1;
        n_checks++;
        if (got_d.size() != 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats, expected 8", got_d.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3 || i == 7)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got d=%h l=%b, expected d=%h l=%b", i,
                         (i < got_d.size()) ? got_d[i] : 32'hx, (i < got_l.size()) ? got_l[i] : 1'bx,
                         exp[i], (i == 3 || i == 7));
            end
        end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_late_finish_err: got %b, expected 0", err); end
    endtask

    task automatic test_early_finish();
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = i + 1;
        send_beats(9, 1'b0, 1'b0);
        in_finish = 1'b1;
        @(negedge h_clk);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL early_err_before: got %b, expected 0", err); end
        @(posedge h_clk);
        #1 in_finish = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL early_err_rise: got %b, expected 1", err); end
        for (int i = 9; i < 16; i++) begin
            in_valid = 1'b1; in_data = fv[i];
            @(posedge h_clk);
            #1 in_valid = 1'b0;
        end
        repeat (2) @(posedge h_clk);
        #1;
        n_checks++;
        if (got_d.size() != 2 || got_d[0] !== 32'd6 || got_d[1] !== 32'd8) begin
            n_fail++;
            $display("FAIL early_outputs: got %0d beats, expected exactly 6,8", got_d.size());
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL early_err_sticky: got %b, expected 1", err); end
    endtask

    task automatic test_invalid();
        apply_reset();
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = i + 1;
        send_beats(5, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = fv[5]; in_invalid = 1'b1;
        @(posedge h_clk);
        #1 in_valid = 1'b0; in_invalid = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL invalid_err: got %b, expected 1", err); end
        for (int i = 6; i < 16; i++) begin
            in_valid = 1'b1; in_data = fv[i];
            @(posedge h_clk);
            #1 in_valid = 1'b0;
        end
        repeat (3) @(posedge h_clk);
        #1;
        n_checks++;
        if (got_d.size() != 0) begin
            n_fail++; $display("FAIL invalid_dropped: got %0d beats, expected 0", got_d.size());
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL invalid_sticky: got %b, expected 1", err); end
    endtask

    task automatic test_midframe_reset();
        logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd14, 32'd16};
        apply_reset();
        for (int i = 0; i < 16; i++) fv[i] = 100 + i;
        send_beats(7, 1'b0, 1'b0);
        apply_reset();
        @(negedge h_clk);
        n_checks++;
        if (out_data !== 32'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got d=%h e=%b, expected d=0 e=0", out_data, err);
        end
        #1;
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 16; i++) fv[i] = i + 1;
        send_beats(16, 1'b0, 1'b1);
        n_checks++;
        if (got_d.size() != 4) begin
            n_fail++; $display("FAIL midreset_count: got %0d beats, expected 4", got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL midreset_beat%0d: got %h, expected %h", i,
                         (i < got_d.size()) ? got_d[i] : 32'hx, exp[i]);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %b, expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negated();
        test_mixed();
        test_back_to_back();
        test_early_finish();
        test_invalid();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
